// File: rtl/sdio_pkg.sv
// Shared definitions for the SDIO command-line blocks: FSM encodings, frame
// geometry, NCR limits and the serial CRC7 step.
package sdio_pkg;

   typedef logic [1:0] rsp_state_t;

   localparam rsp_state_t S_IDLE     = 2'd0;
   localparam rsp_state_t S_WAIT_NCR = 2'd1;
   localparam rsp_state_t S_SHIFT    = 2'd2;
   localparam rsp_state_t S_RELEASE  = 2'd3;

   localparam int         RSP_LEN   = 48;
   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam int         NCR_MIN   = 2;
   localparam int         NCR_MAX   = 64;

   // One serial step of x^7 + x^3 + 1, MSB-first data.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 generator/checker shared by the response transmitter and the
// command sampler. clr has priority over en.
module sdio_crc7
   import sdio_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] r_crc;

   // CRC accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc <= 7'h00;
      end else if (clr) begin
         r_crc <= 7'h00;
      end else if (en) begin
         r_crc <= crc7_step(r_crc, din);
      end else begin
         r_crc <= r_crc;
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/sdio_rsp_tx.sv
// SDIO R1 response transmitter: serialises a 48-bit frame onto the CMD line,
// one bit per falling edge of the (asynchronous) SD clock.
module sdio_rsp_tx
   import sdio_pkg::*;
#(
   parameter int NCR = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        sd_clk,
   input  logic        start,
   input  logic [5:0]  cmd_idx,
   input  logic [31:0] card_status,
   output logic        cmd_o,
   output logic        cmd_oe,
   output logic        busy,
   output logic        done
);

   localparam int         NCR_EFF  = (NCR < NCR_MIN) ? NCR_MIN : ((NCR > NCR_MAX) ? NCR_MAX : NCR);
   localparam logic [6:0] NCR_LOAD = 7'(NCR_EFF);
   localparam logic [5:0] BIT_TOP  = 6'(RSP_LEN - 1);

   logic        r_sd_meta;
   logic        r_sd_sync;
   logic        r_sd_hist;
   logic        w_fe;

   rsp_state_t  r_state;
   logic [6:0]  r_ncr_cnt;
   logic [5:0]  r_bit_cnt;
   logic [5:0]  r_cmd_idx;
   logic [31:0] r_status;
   logic        r_cmd_o;
   logic        r_cmd_oe;
   logic        r_busy;
   logic        r_done;

   logic [6:0]  w_crc;
   logic        w_crc_clr;
   logic        w_crc_en;
   logic [47:0] w_frame;
   logic [5:0]  w_next_idx;
   logic        w_next_bit;
   logic        w_advance;

   // SD clock synchroniser plus history flop for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sd_meta <= 1'b0;
         r_sd_sync <= 1'b0;
         r_sd_hist <= 1'b0;
      end else begin
         r_sd_meta <= sd_clk;
         r_sd_sync <= r_sd_meta;
         r_sd_hist <= r_sd_sync;
      end
   end

   assign w_fe = r_sd_hist & ~r_sd_sync;

   // CRC bits are only read once bit 8 has been fed, so the live CRC value is final by then
   always_comb begin
      w_frame    = {2'b00, r_cmd_idx, r_status, w_crc, 1'b1};
      w_next_idx = 6'd0;
      w_advance  = 1'b0;
      if (r_state == S_WAIT_NCR) begin
         w_next_idx = BIT_TOP;
         w_advance  = w_fe && (r_ncr_cnt == 7'd1);
      end else if ((r_state == S_SHIFT) && (r_bit_cnt != 6'd0)) begin
         w_next_idx = r_bit_cnt - 6'd1;
         w_advance  = w_fe;
      end else begin
         w_next_idx = 6'd0;
         w_advance  = 1'b0;
      end
      w_next_bit = w_frame[w_next_idx];
      w_crc_clr  = (r_state == S_IDLE) && start;
      if (w_advance && (w_next_idx >= 6'd8)) begin
         w_crc_en = 1'b1;
      end else begin
         w_crc_en = 1'b0;
      end
   end

   sdio_crc7 u_crc7 (
      .clk (clk),
      .rst (rst),
      .clr (w_crc_clr),
      .en  (w_crc_en),
      .din (w_next_bit),
      .crc (w_crc)
   );

   // Response FSM and registered line outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ncr_cnt <= 7'd0;
         r_bit_cnt <= 6'd0;
         r_cmd_idx <= 6'd0;
         r_status  <= 32'd0;
         r_cmd_o   <= 1'b1;
         r_cmd_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cmd_idx <= cmd_idx;
                  r_status  <= card_status;
                  r_ncr_cnt <= NCR_LOAD;
                  r_busy    <= 1'b1;
                  r_state   <= S_WAIT_NCR;
               end
            end
            S_WAIT_NCR: begin
               if (w_fe) begin
                  if (r_ncr_cnt == 7'd1) begin
                     r_ncr_cnt <= 7'd0;
                     r_bit_cnt <= BIT_TOP;
                     r_cmd_o   <= w_next_bit;
                     r_cmd_oe  <= 1'b1;
                     r_state   <= S_SHIFT;
                  end else begin
                     r_ncr_cnt <= r_ncr_cnt - 7'd1;
                  end
               end
            end
            S_SHIFT: begin
               if (w_fe) begin
                  if (r_bit_cnt == 6'd0) begin
                     r_cmd_o  <= 1'b1;
                     r_cmd_oe <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= S_RELEASE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 6'd1;
                     r_cmd_o   <= w_next_bit;
                  end
               end
            end
            S_RELEASE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_cmd_o  <= 1'b1;
               r_cmd_oe <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_o  = r_cmd_o;
   assign cmd_oe = r_cmd_oe;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_sdio_rsp_tx.sv
// Directed bench for sdio_rsp_tx and sdio_crc7: the bench plays host, toggling
// sd_clk and capturing cmd_o on each rising sd_clk edge while cmd_oe is high.
`timescale 1ns/1ps
module tb_sdio_rsp_tx;

   localparam int NCR  = 2;
   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        sd_clk;
   logic        start;
   logic [5:0]  cmd_idx;
   logic [31:0] card_status;
   logic        cmd_o;
   logic        cmd_oe;
   logic        busy;
   logic        done;

   logic        c_clr;
   logic        c_en;
   logic        c_din;
   logic [6:0]  c_crc;

   int          vec_n = 0;
   int          err_n = 0;
   bit          sd_run = 1'b0;
   int          half_cnt;
   int          fe_count;
   logic [47:0] cap_bits;
   int          cap_n;
   int          first_fe;
   int          done_cnt = 0;

   localparam logic [47:0] EXP_17 = {2'b00, 6'd17, 32'h0000_0900, 7'h33, 1'b1};
   localparam logic [47:0] EXP_00 = {2'b00, 6'd0, 32'h0000_0000, 7'h00, 1'b1};

   sdio_rsp_tx #(.NCR(NCR)) dut (
      .clk         (clk),
      .rst         (rst),
      .sd_clk      (sd_clk),
      .start       (start),
      .cmd_idx     (cmd_idx),
      .card_status (card_status),
      .cmd_o       (cmd_o),
      .cmd_oe      (cmd_oe),
      .busy        (busy),
      .done        (done)
   );

   sdio_crc7 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (c_clr),
      .en  (c_en),
      .din (c_din),
      .crc (c_crc)
   );

   always #5 clk = ~clk;

   // Host side: sd_clk generator and rising-edge capture of the CMD line
   initial begin
      sd_clk   = 1'b1;
      half_cnt = 0;
      fe_count = 0;
      cap_n    = 0;
      cap_bits = '0;
      first_fe = -1;
      forever begin
         @(negedge clk);
         if (sd_run) begin
            half_cnt++;
            if (half_cnt >= HALF) begin
               half_cnt = 0;
               if (sd_clk) begin
                  sd_clk = 1'b0;
                  fe_count++;
               end else begin
                  sd_clk = 1'b1;
                  if (cmd_oe === 1'b1) begin
                     cap_bits = {cap_bits[46:0], cmd_o};
                     cap_n++;
                     if (cap_n == 1) first_fe = fe_count;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic clear_capture();
      cap_n    = 0;
      cap_bits = '0;
      first_fe = -1;
      fe_count = 0;
   endtask

   // Start a frame with sd_clk freshly high so no stale falling edge is in flight
   task automatic send_start(input logic [5:0] idx, input logic [31:0] st, output bit to);
      int n;
      n  = 0;
      to = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (sd_clk && half_cnt >= 1 && half_cnt <= 2) begin
            to = 1'b0;
            break;
         end
      end
      clear_capture();
      cmd_idx     = idx;
      card_status = st;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int n;
      n  = 0;
      to = 1'b1;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_cap(input int count, output bit to);
      int n;
      n  = 0;
      to = 1'b1;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         if (cap_n >= count) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; cmd_idx = 6'd0; card_status = 32'd0;
      c_clr = 1'b0; c_en = 1'b0; c_din = 1'b0;
      sd_run = 1'b1;
      repeat (3) @(negedge clk);
      vec_n++; if (cmd_o !== 1'b1)  begin err_n++; $display("FAIL reset_cmd_o: got %b expected 1", cmd_o); end
      vec_n++; if (cmd_oe !== 1'b0) begin err_n++; $display("FAIL reset_cmd_oe: got %b expected 0", cmd_oe); end
      vec_n++; if (busy !== 1'b0)   begin err_n++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vec_n++; if (done !== 1'b0)   begin err_n++; $display("FAIL reset_done: got %b expected 0", done); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      vec_n++; if (busy !== 1'b0 || cmd_oe !== 1'b0) begin err_n++; $display("FAIL idle_after_reset: busy=%b oe=%b expected 0 0", busy, cmd_oe); end
   endtask

   task automatic test_crc7();
      logic [39:0] v;
      v = 40'h40_0000_0000;
      @(negedge clk); c_clr = 1'b1;
      @(negedge clk); c_clr = 1'b0;
      vec_n++; if (c_crc !== 7'h00) begin err_n++; $display("FAIL crc_clear: got %h expected 00", c_crc); end
      for (int i = 39; i >= 0; i--) begin
         c_en = 1'b1; c_din = v[i];
         @(negedge clk);
      end
      c_en = 1'b0;
      vec_n++; if (c_crc !== 7'h4A) begin err_n++; $display("FAIL crc_cmd0: got %h expected 4a", c_crc); end
      v = {2'b00, 6'd17, 32'h0000_0900};
      c_clr = 1'b1;
      @(negedge clk); c_clr = 1'b0;
      for (int i = 39; i >= 0; i--) begin
         c_en = 1'b1; c_din = v[i];
         @(negedge clk);
      end
      c_en = 1'b0;
      vec_n++; if (c_crc !== 7'h33) begin err_n++; $display("FAIL crc_r1: got %h expected 33", c_crc); end
   endtask

   task automatic test_frame();
      bit to;
      int d0;
      send_start(6'd17, 32'h0000_0900, to);
      vec_n++; if (to) begin err_n++; $display("FAIL frame_align: timed out"); end
      vec_n++; if (busy !== 1'b1 || cmd_oe !== 1'b0) begin err_n++; $display("FAIL frame_accept: busy=%b oe=%b expected 1 0", busy, cmd_oe); end
      d0 = done_cnt;
      wait_done(2000, to);
      vec_n++; if (to) begin err_n++; $display("FAIL frame_done: timed out"); end
      vec_n++; if (cap_n !== 48) begin err_n++; $display("FAIL frame_oe_bits: got %0d expected 48", cap_n); end
      vec_n++; if (cap_bits !== EXP_17) begin err_n++; $display("FAIL frame_bits: got %h expected %h", cap_bits, EXP_17); end
      vec_n++; if (first_fe !== NCR) begin err_n++; $display("FAIL frame_ncr: first bit after fe %0d expected %0d", first_fe, NCR); end
      vec_n++; if (cmd_oe !== 1'b0 || cmd_o !== 1'b1) begin err_n++; $display("FAIL frame_release: oe=%b o=%b expected 0 1", cmd_oe, cmd_o); end
      @(negedge clk);
      vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
      vec_n++; if (done_cnt - d0 !== 1) begin err_n++; $display("FAIL frame_done_cnt: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_start_ignored();
      bit to;
      bit seen;
      int d0;
      int drops;
      int n;
      send_start(6'd17, 32'h0000_0900, to);
      vec_n++; if (to) begin err_n++; $display("FAIL ign_align: timed out"); end
      d0 = done_cnt; drops = 0; n = 0; seen = 1'b0;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy !== 1'b1) drops++;
         if (n % 10 == 0) begin
            cmd_idx = 6'd63; card_status = 32'hFFFF_FFFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      vec_n++; if (!seen) begin err_n++; $display("FAIL ign_done: timed out"); end
      vec_n++; if (drops !== 0) begin err_n++; $display("FAIL ign_busy: busy low %0d clk mid-frame expected 0", drops); end
      vec_n++; if (cap_bits !== EXP_17 || cap_n !== 48) begin err_n++; $display("FAIL ign_bits: got %h/%0d expected %h/48", cap_bits, cap_n, EXP_17); end
      repeat (40) @(negedge clk);
      vec_n++; if (busy !== 1'b0 || cmd_oe !== 1'b0) begin err_n++; $display("FAIL ign_idle: busy=%b oe=%b expected 0 0", busy, cmd_oe); end
      vec_n++; if (done_cnt - d0 !== 1) begin err_n++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_reset_midframe();
      bit to;
      int d0;
      send_start(6'd17, 32'h0000_0900, to);
      wait_cap(28, to);
      vec_n++; if (to) begin err_n++; $display("FAIL rst_reach_bit20: timed out"); end
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      vec_n++; if (cmd_oe !== 1'b0 || cmd_o !== 1'b1) begin err_n++; $display("FAIL rst_line: oe=%b o=%b expected 0 1", cmd_oe, cmd_o); end
      vec_n++; if (busy !== 1'b0 || done !== 1'b0) begin err_n++; $display("FAIL rst_flags: busy=%b done=%b expected 0 0", busy, done); end
      rst = 1'b0;
      repeat (600) @(negedge clk);
      vec_n++; if (done_cnt !== d0 || cmd_oe !== 1'b0) begin err_n++; $display("FAIL rst_no_done: done pulses %0d oe=%b expected 0 0", done_cnt - d0, cmd_oe); end
      send_start(6'd17, 32'h0000_0900, to);
      wait_done(2000, to);
      vec_n++; if (to) begin err_n++; $display("FAIL rst_refr_done: timed out"); end
      vec_n++; if (cap_bits !== EXP_17 || cap_n !== 48 || first_fe !== NCR) begin err_n++; $display("FAIL rst_refr_bits: got %h/%0d/fe%0d expected %h/48/fe%0d", cap_bits, cap_n, first_fe, EXP_17, NCR); end
      @(negedge clk);
   endtask

   task automatic test_freeze();
      bit to;
      logic held;
      int changes;
      send_start(6'd17, 32'h0000_0900, to);
      wait_cap(18, to);
      vec_n++; if (to) begin err_n++; $display("FAIL frz_reach_bit30: timed out"); end
      sd_run = 1'b0;
      held = cmd_o;
      vec_n++; if (held !== 1'b0) begin err_n++; $display("FAIL frz_bit30: got %b expected 0", held); end
      changes = 0;
      repeat (1000) begin
         @(negedge clk);
         if (cmd_o !== held || cmd_oe !== 1'b1 || busy !== 1'b1) changes++;
      end
      vec_n++; if (changes !== 0 || cap_n !== 18) begin err_n++; $display("FAIL frz_hold: %0d unstable clk, %0d bits expected 0, 18", changes, cap_n); end
      sd_run = 1'b1;
      wait_done(2000, to);
      vec_n++; if (to) begin err_n++; $display("FAIL frz_done: timed out"); end
      vec_n++; if (cap_bits !== EXP_17 || cap_n !== 48) begin err_n++; $display("FAIL frz_bits: got %h/%0d expected %h/48", cap_bits, cap_n, EXP_17); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit to;
      send_start(6'd17, 32'h0000_0900, to);
      wait_done(2000, to);
      vec_n++; if (to) begin err_n++; $display("FAIL b2b_first_done: timed out"); end
      // start coincident with done carries data that must not be latched
      cmd_idx = 6'd5; card_status = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL b2b_coincident: busy=%b expected 0", busy); end
      clear_capture();
      cmd_idx = 6'd0; card_status = 32'h0000_0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec_n++; if (busy !== 1'b1) begin err_n++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
      wait_done(2000, to);
      vec_n++; if (to) begin err_n++; $display("FAIL b2b_done: timed out"); end
      vec_n++; if (cap_bits !== EXP_00 || cap_n !== 48) begin err_n++; $display("FAIL b2b_bits: got %h/%0d expected %h/48", cap_bits, cap_n, EXP_00); end
      vec_n++; if (first_fe !== NCR) begin err_n++; $display("FAIL b2b_ncr: first bit after fe %0d expected %0d", first_fe, NCR); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_crc7();
      test_frame();
      test_start_ignored();
      test_reset_midframe();
      test_freeze();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

endmodule
